// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl_if
//  Brief    : Button inputs and count-control outputs of the stopwatch
//             control stage, grouped as one bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
  logic       i_start_stop;  // raw start/stop button, active-high
  logic       i_clear;       // raw clear button, active-high
  logic       o_tick;        // one-cycle count enable
  logic       o_clear;       // one-cycle synchronous clear
  logic       o_running;     // high while in RUN
  logic [1:0] o_state;       // IDLE=00, RUN=01, PAUSE=10

  // Board/bench side: drives the buttons, observes the controls
  modport master (
    output i_start_stop,
    output i_clear,
    input  o_tick,
    input  o_clear,
    input  o_running,
    input  o_state
  );

  // Controller side
  modport slave (
    input  i_start_stop,
    input  i_clear,
    output o_tick,
    output o_clear,
    output o_running,
    output o_state
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Brief    : Synchronises and debounces start/stop and clear buttons, runs
//             the IDLE/RUN/PAUSE machine and produces count-enable ticks and
//             clear pulses for the downstream counter chain.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DIV  = 500000,  // clk cycles per tick while running (>= 2)
  parameter int DBNC = 16       // stable cycles to accept a level change (>= 1)
) (
  input  wire logic       clk,
  input  wire logic       sreset,
  stopwatch_ctrl_if.slave bus
);

  localparam int C_CNT_W = $clog2(DBNC + 1);
  localparam int C_PRE_W = $clog2(DIV);

  localparam logic [C_CNT_W-1:0] C_DBNC_LAST = C_CNT_W'(DBNC - 1);
  localparam logic [C_PRE_W-1:0] C_DIV_LAST  = C_PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Bit 0 = start/stop, bit 1 = clear
  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {bus.i_clear, bus.i_start_stop};

  // --------------------------------------------------------------------------
  // Per-button conditioning: 2-flop synchroniser, debounce, rising-edge event
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               stable_q, stable_d;
    logic               stable_prev_q, stable_prev_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: the counter measures how long s2 has disagreed with the
    // accepted level; the level follows s2 once it has disagreed DBNC times
    always_comb begin
      s1_d          = w_btn_raw[b];
      s2_d          = s1_q;
      stable_prev_d = stable_q;
      stable_d      = stable_q;
      cnt_d         = cnt_q;
      if (s2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == C_DBNC_LAST) begin
        stable_d = s2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Conditioning registers
    always_ff @(posedge clk) begin
      if (sreset) begin
        s1_q          <= 1'b0;
        s2_q          <= 1'b0;
        stable_q      <= 1'b0;
        stable_prev_q <= 1'b0;
        cnt_q         <= '0;
      end else begin
        s1_q          <= s1_d;
        s2_q          <= s2_d;
        stable_q      <= stable_d;
        stable_prev_q <= stable_prev_d;
        cnt_q         <= cnt_d;
      end
    end

    // Only an accepted press (rising level) is an event; releases are silent
    assign w_press[b] = stable_q & ~stable_prev_q;
  end

  // --------------------------------------------------------------------------
  // Control state machine and tick prescaler
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [C_PRE_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;
  logic               clear_q, clear_d;
  logic               running_q, running_d;

  // Next-state/output logic; the tick decision uses the pre-edge state so a
  // wrap coinciding with RUN->PAUSE still issues its tick
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_press[1]) begin
          clear_d = 1'b1;
        end else if (w_press[0]) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Clear is ignored while running; start/stop wins a tie
        if (w_press[0]) begin
          state_d = ST_PAUSE;
        end
        if (presc_q == C_DIV_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        // Prescaler holds here so the tick phase survives the pause
        if (w_press[1]) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (w_press[0]) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (clear_d) begin
      presc_d = '0;
    end
    running_d = (state_d == ST_RUN);
  end

  // Control registers; all outputs come straight from flops
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
      running_q <= running_d;
    end
  end

  assign bus.o_tick    = tick_q;
  assign bus.o_clear   = clear_q;
  assign bus.o_running = running_q;
  assign bus.o_state   = state_q;

endmodule
`default_nettype wire
